phase_select_downsampler: RTL and testbench
===========================================

Name: phase_select_downsampler

Overview:
- Consumer side of the 4x oversampling phase counter: takes the oversampled sample stream (one sample per enable) and decimates it to one sample per symbol.
- Estimates the best sampling phase by accumulating per-phase energy over a window of symbols, then selects the maximum-energy phase.
- Sits after the polyphase/matched filter and before the symbol-rate slicer/equalizer. Exposes its own phase counter so downstream symbol-rate logic can align to it.

Parameters:
- NB_DATA, 8, signed input/output sample width.
- NB_ACC, 24, per-phase energy accumulator width (unsigned, saturating); must be >= 2*NB_DATA.
- LOG2_WIN, 10, estimation window = 2**LOG2_WIN symbols.

Ports:
- clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_enable  in  1  oversampled sample valid; all state advances only when high.
- i_data  in  NB_DATA  signed oversampled sample.
- i_phase_force_en  in  1  1 = use i_phase_force instead of the estimated phase.
- i_phase_force  in  2  forced sampling phase 0..3.
- o_data  out  NB_DATA  decimated symbol-rate sample.
- o_valid  out  1  one-cycle strobe, o_data valid.
- o_phase  out  2  phase currently applied to decimation.
- o_phase_locked  out  1  high after the first estimation window completes.
- o_counter  out  2  internal oversampling phase counter.

Behaviour:
- Reset (i_reset=0, async):
  - r_counter=0, applied phase=0, pending phase=0, estimated phase=0.
  - All accumulators and the symbol counter = 0; FSM=ACQ.
  - o_data=0, o_valid=0, o_phase_locked=0.
- Phase counter:
  - On i_enable: 0->1->2->3->0.
  - With i_enable=0 every register holds, except o_valid, which clears to 0.
  - A "wrap" is i_enable with r_counter==3.
- Decimation:
  - On i_enable with r_counter==applied phase: o_data<=i_data and o_valid=1 on the next clock (latency 1 clk), else o_valid=0.
- Energy:
  - e = i_data*i_data, unsigned, 2*NB_DATA bits, zero-extended.
  - On i_enable, acc[r_counter] += e, saturating at 2**NB_ACC-1 (never wraps).
- Window:
  - The symbol counter (LOG2_WIN bits) increments on every wrap.
  - On the wrap where the symbol counter is all ones:
    - Snapshot all 4 accumulators, with the current sample's energy included in acc[3].
    - Clear the accumulators to 0 and roll the symbol counter to 0.
    - Go to DECIDE.
  - Accumulation of the new window continues without gaps.
- FSM states ACQ, DECIDE, TRACK:
  - ACQ -> DECIDE on window end.
  - DECIDE (exactly 1 clk): estimated phase = argmax of the snapshot; ties resolve to the lowest index. Sets o_phase_locked=1, then -> TRACK.
  - TRACK -> DECIDE on each subsequent window end.
  - o_phase_locked stays 1 until reset.
- Phase application:
  - pending phase = i_phase_force_en ? i_phase_force : estimated phase, evaluated combinationally.
  - Applied phase loads from pending only on a wrap, so every symbol produces exactly one o_valid, even when the phase changes 3->0 or 0->3.
  - o_phase = applied phase.
- Simultaneous events: a window end coinciding with a force change needs no special case. The force value applies at that wrap; the new estimate applies at the next wrap.
- Reset mid-window: discards all partial accumulation; the next estimate requires a full window.

Decomposition:
- Shared package:
  - OS factor 4 and phase width 2.
  - FSM state encoding ACQ/DECIDE/TRACK.
  - Saturation max helper constant.
- One sub-module: phase_argmax. It is combinational: 4 x NB_ACC inputs -> 2-bit index, lowest index on ties.
- The registered DECIDE stage lives in the parent.

Test Plan:
1. Reset held low for 3 clk mid-stream -> every output 0 immediately (async), o_counter=0; after release, first o_valid follows the 1st enable (phase 0).
2. LOG2_WIN=4, continuous enable, i_data=+100 at counter 2 and 0 elsewhere:
   - After 16 symbols, o_phase_locked=1 one clk after the window-end wrap.
   - o_phase=2 after the next wrap.
   - Thereafter o_data=100 with o_valid every 4 enables; exactly one o_valid per symbol across the switch.
3. All phases with equal |i_data|=50 -> estimate=0 (tie rule); o_phase stays 0.
4. Locked at phase 2, then i_phase_force_en=1, i_phase_force=1 asserted mid-symbol:
   - o_phase changes to 1 only at the next wrap, with no double or missing o_valid.
   - Deasserting force returns to 2 at the following wrap.
5. i_enable toggling 1,0,1,0 -> o_counter advances only on enables, o_valid once per 4 enables, accumulators unchanged on idle cycles.
6. NB_ACC=16, i_data=-128 continuous, LOG2_WIN=4 -> accumulators saturate at 0xFFFF (no wrap); tie -> estimate 0.

Source files
------------

// File: rtl/phase_select_downsampler_pkg.sv
// Shared definitions for the phase-select downsampler.
//   OS / PHASE_W : oversampling factor and phase index width
//   state_t      : estimation FSM encoding (ACQ, DECIDE, TRACK)
//   sat_max()    : all-ones value of an nb-bit unsigned accumulator (nb < 64)
package phase_select_downsampler_pkg;

  localparam int OS      = 4;
  localparam int PHASE_W = 2;

  typedef enum logic [1:0] {
    ST_ACQ    = 2'd0,
    ST_DECIDE = 2'd1,
    ST_TRACK  = 2'd2
  } state_t;

  function automatic logic [63:0] sat_max(input int nb);
    return (64'd1 << nb) - 64'd1;
  endfunction

endpackage

// File: rtl/phase_select_downsampler_if.sv
// Sample stream bundle between the oversampled source and the downsampler.
//   i_enable / i_data : oversampled input, one sample per cycle with i_enable high
//   o_valid  / o_data : symbol-rate output, o_data is meaningful only while o_valid
// Handshake: valid-only, no backpressure. A transfer happens on every clock
// edge where the valid signal (i_enable or o_valid) is high; the receiver must
// always accept. o_valid is a one-cycle strobe per symbol.
interface phase_select_downsampler_if #(
  parameter int NB_DATA = 8
);
  logic                      i_enable;
  logic signed [NB_DATA-1:0] i_data;
  logic signed [NB_DATA-1:0] o_data;
  logic                      o_valid;

  modport master (
    output i_enable, i_data,
    input  o_data, o_valid
  );

  modport slave (
    input  i_enable, i_data,
    output o_data, o_valid
  );
endinterface

// File: rtl/phase_select_downsampler_argmax.sv
// Combinational argmax over the four per-phase energy snapshots.
//   vals : four NB_ACC-bit unsigned energies, index 0..3
//   idx  : index of the largest value; ties resolve to the lowest index
module phase_select_downsampler_argmax
  import phase_select_downsampler_pkg::*;
#(
  parameter int NB_ACC = 24
) (
  input  logic [OS-1:0][NB_ACC-1:0] vals,
  output logic [PHASE_W-1:0]        idx
);

  logic [NB_ACC-1:0] best;

  // Strict '>' keeps the earlier (lower) index when values are equal.
  always_comb begin
    idx  = '0;
    best = vals[0];
    for (int i = 1; i < OS; i++) begin
      if (vals[i] > best) begin
        best = vals[i];
        idx  = PHASE_W'(i);
      end
    end
  end

endmodule

// File: rtl/phase_select_downsampler.sv
// Phase-select downsampler: decimates a 4x oversampled stream to symbol rate,
// choosing the sampling phase with the highest energy over a window of
// 2**LOG2_WIN symbols (or a forced phase).
//   clk              : system clock
//   i_reset          : asynchronous active-low reset
//   bus              : sample stream (i_enable/i_data in, o_valid/o_data out)
//   i_phase_force_en : use i_phase_force instead of the estimate
//   i_phase_force    : forced phase 0..3
//   o_phase          : phase currently applied to decimation
//   o_phase_locked   : high once the first estimation window has completed
//   o_counter        : internal oversampling phase counter
//   o_state          : estimation FSM state (debug)
// NB_ACC must be >= 2*NB_DATA.
module phase_select_downsampler
  import phase_select_downsampler_pkg::*;
#(
  parameter int NB_DATA  = 8,
  parameter int NB_ACC   = 24,
  parameter int LOG2_WIN = 10
) (
  input  logic                clk,
  input  logic                i_reset,
  phase_select_downsampler_if.slave bus,
  input  logic                i_phase_force_en,
  input  logic [PHASE_W-1:0]  i_phase_force,
  output logic [PHASE_W-1:0]  o_phase,
  output logic                o_phase_locked,
  output logic [PHASE_W-1:0]  o_counter,
  output state_t              o_state
);

  localparam logic [NB_ACC-1:0] ACC_MAX = NB_ACC'(sat_max(NB_ACC));

  logic [PHASE_W-1:0]        r_counter;
  logic [PHASE_W-1:0]        applied_phase;
  logic [PHASE_W-1:0]        est_phase;
  logic [PHASE_W-1:0]        pending_phase;
  logic [PHASE_W-1:0]        best_phase;
  logic [LOG2_WIN-1:0]       sym_cnt;
  logic [NB_ACC-1:0]         acc [OS];
  logic [OS-1:0][NB_ACC-1:0] snap;
  state_t                    state;

  logic                      wrap;
  logic                      win_end;
  logic signed [2*NB_DATA-1:0] prod;
  logic [2*NB_DATA-1:0]      energy;
  logic [NB_ACC:0]           sum;
  logic [NB_ACC-1:0]         acc_sat;

  assign wrap    = bus.i_enable && (r_counter == PHASE_W'(OS - 1));
  assign win_end = wrap && (sym_cnt == '1);

  // A square is never negative, so the signed product reads as unsigned.
  assign prod    = bus.i_data * bus.i_data;
  assign energy  = prod;
  // One spare carry bit detects overflow; saturate instead of wrapping.
  assign sum     = {1'b0, acc[r_counter]} + {{(NB_ACC + 1 - 2*NB_DATA){1'b0}}, energy};
  assign acc_sat = sum[NB_ACC] ? ACC_MAX : sum[NB_ACC-1:0];

  assign pending_phase = i_phase_force_en ? i_phase_force : est_phase;

  phase_select_downsampler_argmax #(.NB_ACC(NB_ACC)) u_argmax (
    .vals (snap),
    .idx  (best_phase)
  );

  // Datapath: counter, decimation, energy accumulation, window bookkeeping.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      r_counter     <= '0;
      applied_phase <= '0;
      sym_cnt       <= '0;
      bus.o_data    <= '0;
      bus.o_valid   <= 1'b0;
      snap          <= '0;
      for (int i = 0; i < OS; i++) acc[i] <= '0;
    end else begin
      bus.o_valid <= 1'b0;
      if (bus.i_enable) begin
        r_counter <= r_counter + PHASE_W'(1);
        if (r_counter == applied_phase) begin
          bus.o_data  <= bus.i_data;
          bus.o_valid <= 1'b1;
        end
        acc[r_counter] <= acc_sat;
        // Phase changes only at a symbol boundary so each symbol yields
        // exactly one output sample.
        if (wrap) begin
          sym_cnt       <= sym_cnt + 1'b1;
          applied_phase <= pending_phase;
        end
        // Window end: the current sample (phase 3) is part of the closing
        // window; the clear below overrides the acc write above so the next
        // window starts from zero on the very next sample.
        if (win_end) begin
          for (int i = 0; i < OS - 1; i++) snap[i] <= acc[i];
          snap[OS-1] <= acc_sat;
          for (int i = 0; i < OS; i++) acc[i] <= '0;
        end
      end
    end
  end

  // Estimation FSM: DECIDE registers the argmax of the snapshot for one clock.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state          <= ST_ACQ;
      est_phase      <= '0;
      o_phase_locked <= 1'b0;
    end else begin
      case (state)
        ST_ACQ: begin
          if (win_end) state <= ST_DECIDE;
        end
        ST_DECIDE: begin
          est_phase      <= best_phase;
          o_phase_locked <= 1'b1;
          state          <= win_end ? ST_DECIDE : ST_TRACK;
        end
        ST_TRACK: begin
          if (win_end) state <= ST_DECIDE;
        end
        default: state <= ST_ACQ;
      endcase
    end
  end

  assign o_phase   = applied_phase;
  assign o_counter = r_counter;
  assign o_state   = state;

endmodule

// File: tb/tb_phase_select_downsampler.sv
module tb_phase_select_downsampler;
  import phase_select_downsampler_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  phase_select_downsampler_if #(.NB_DATA(8)) bus_a ();
  phase_select_downsampler_if #(.NB_DATA(8)) bus_b ();

  logic         force_en_a, force_en_b;
  logic [1:0]   force_a, force_b;
  logic [1:0]   phase_a, phase_b, cnt_a, cnt_b;
  logic         locked_a, locked_b;
  state_t       state_a, state_b;

  phase_select_downsampler #(.NB_DATA(8), .NB_ACC(24), .LOG2_WIN(4)) dut_a (
    .clk              (clk),
    .i_reset          (rst_n),
    .bus              (bus_a.slave),
    .i_phase_force_en (force_en_a),
    .i_phase_force    (force_a),
    .o_phase          (phase_a),
    .o_phase_locked   (locked_a),
    .o_counter        (cnt_a),
    .o_state          (state_a)
  );

  phase_select_downsampler #(.NB_DATA(8), .NB_ACC(16), .LOG2_WIN(4)) dut_b (
    .clk              (clk),
    .i_reset          (rst_n),
    .bus              (bus_b.slave),
    .i_phase_force_en (force_en_b),
    .i_phase_force    (force_b),
    .o_phase          (phase_b),
    .o_phase_locked   (locked_b),
    .o_counter        (cnt_b),
    .o_state          (state_b)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int vcount = 0;
  logic [31:0] vdata = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    bus_a.i_enable = 1'b0;
    bus_b.i_enable = 1'b0;
    force_en_a     = 1'b0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    vcount = 0;
  endtask

  task automatic step(input logic en, input int d);
    @(negedge clk);
    bus_a.i_enable = en;
    bus_a.i_data   = 8'(d);
    @(posedge clk);
    #1;
    if (bus_a.o_valid) begin
      vcount++;
      vdata = 32'(bus_a.o_data);
    end
  endtask

  task automatic run_sym(input string tag, input int d0, input int d1, input int d2, input int d3);
    vcount = 0;
    step(1'b1, d0);
    step(1'b1, d1);
    step(1'b1, d2);
    step(1'b1, d3);
    chk(tag, 32'(vcount), 32'd1);
  endtask

  task automatic step_b(input int d);
    @(negedge clk);
    bus_b.i_enable = 1'b1;
    bus_b.i_data   = 8'(d);
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n          = 1'b0;
    bus_a.i_enable = 1'b0;
    bus_a.i_data   = '0;
    bus_b.i_enable = 1'b0;
    bus_b.i_data   = '0;
    force_en_a     = 1'b0;
    force_a        = 2'd0;
    force_en_b     = 1'b0;
    force_b        = 2'd0;

    // T1: reset values, async reset mid-stream, first valid after release
    #2;
    chk("rst_valid",  32'(bus_a.o_valid), 32'd0);
    chk("rst_data",   32'(bus_a.o_data),  32'd0);
    chk("rst_locked", 32'(locked_a),      32'd0);
    chk("rst_state",  32'(state_a),       32'(ST_ACQ));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 55);
    chk("t1_valid", 32'(bus_a.o_valid), 32'd1);
    chk("t1_data",  32'(bus_a.o_data),  32'(8'sd55));
    chk("t1_cnt",   32'(cnt_a),         32'd1);
    step(1'b1, 7);
    step(1'b1, 7);
    step(1'b1, 7);
    step(1'b1, 33);
    chk("t1_valid2", 32'(bus_a.o_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus_a.o_valid), 32'd0);
    chk("arst_data",  32'(bus_a.o_data),  32'd0);
    chk("arst_cnt",   32'(cnt_a),         32'd0);
    chk("arst_phase", 32'(phase_a),       32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus_a.i_enable = 1'b0;
    rst_n = 1'b1;
    step(1'b1, 66);
    chk("rel_valid", 32'(bus_a.o_valid), 32'd1);
    chk("rel_data",  32'(bus_a.o_data),  32'(8'sd66));

    // T2: energy only at phase 2 -> lock and switch to phase 2
    do_reset();
    for (int s = 0; s < 16; s++) run_sym("t2_one_valid", 0, 0, 100, 0);
    chk("t2_lock_pre",  32'(locked_a), 32'd0);
    chk("t2_decide",    32'(state_a),  32'(ST_DECIDE));
    vcount = 0;
    step(1'b1, 0);
    chk("t2_lock",      32'(locked_a), 32'd1);
    chk("t2_track",     32'(state_a),  32'(ST_TRACK));
    chk("t2_ph_hold",   32'(phase_a),  32'd0);
    step(1'b1, 0);
    step(1'b1, 100);
    step(1'b1, 0);
    chk("t2_sw_one",    32'(vcount),   32'd1);
    chk("t2_phase2",    32'(phase_a),  32'd2);
    run_sym("t2_post_one", 0, 0, 100, 0);
    chk("t2_data100",   vdata,         32'd100);
    run_sym("t2_post_one", 0, 0, 100, 0);
    chk("t2_data100b",  vdata,         32'd100);

    // T4: force phase 1 mid-symbol, then release back to 2
    vcount = 0;
    step(1'b1, 0);
    force_en_a = 1'b1;
    force_a    = 2'd1;
    step(1'b1, 0);
    step(1'b1, 100);
    chk("t4_ph_still2", 32'(phase_a), 32'd2);
    step(1'b1, 0);
    chk("t4_one_valid", 32'(vcount),  32'd1);
    chk("t4_phase1",    32'(phase_a), 32'd1);
    run_sym("t4_forced_one", 0, 77, 100, 0);
    chk("t4_data77",    vdata,        32'd77);
    force_en_a = 1'b0;
    run_sym("t4_rel_one", 0, 0, 100, 0);
    chk("t4_phase2",    32'(phase_a), 32'd2);
    run_sym("t4_back_one", 0, 0, 100, 0);
    chk("t4_data100",   vdata,        32'd100);

    // T3: equal energy on all phases -> tie resolves to phase 0
    do_reset();
    for (int s = 0; s < 16; s++) run_sym("t3_one_valid", 50, -50, 50, -50);
    run_sym("t3_post_one", 50, -50, 50, -50);
    chk("t3_lock",   32'(locked_a), 32'd1);
    chk("t3_phase0", 32'(phase_a),  32'd0);
    chk("t3_data",   vdata,         32'd50);

    // T5: enable toggling
    do_reset();
    vcount = 0;
    step(1'b1, 10);
    chk("t5_cnt1",   32'(cnt_a),         32'd1);
    chk("t5_valid",  32'(bus_a.o_valid), 32'd1);
    step(1'b0, 99);
    chk("t5_hold_cnt",   32'(cnt_a),          32'd1);
    chk("t5_idle_valid", 32'(bus_a.o_valid),  32'd0);
    chk("t5_acc0",       32'(dut_a.acc[0]),   32'd100);
    chk("t5_acc1_idle",  32'(dut_a.acc[1]),   32'd0);
    step(1'b1, 20);
    chk("t5_acc1",       32'(dut_a.acc[1]),   32'd400);
    step(1'b0, 99);
    chk("t5_cnt2",       32'(cnt_a),          32'd2);
    chk("t5_acc1_hold",  32'(dut_a.acc[1]),   32'd400);
    step(1'b1, 30);
    step(1'b0, 99);
    step(1'b1, 40);
    step(1'b0, 99);
    chk("t5_cnt0",       32'(cnt_a),          32'd0);
    step(1'b1, 11);
    step(1'b0, 99);
    chk("t5_vcount",     32'(vcount),         32'd2);
    chk("t5_vdata",      vdata,               32'd11);

    // T6: NB_ACC=16 saturation with -128 continuous
    do_reset();
    step_b(-128);
    chk("t6_valid", 32'(bus_b.o_valid), 32'd1);
    chk("t6_data",  32'(bus_b.o_data),  32'(-128));
    for (int i = 1; i < 20; i++) step_b(-128);
    for (int k = 0; k < 4; k++) chk("t6_acc_sat", 32'(dut_b.acc[k]), 32'hFFFF);
    for (int i = 20; i < 64; i++) step_b(-128);
    for (int k = 0; k < 4; k++) chk("t6_snap_sat", 32'(dut_b.snap[k]), 32'hFFFF);
    chk("t6_acc_clr", 32'(dut_b.acc[0]), 32'd0);
    for (int i = 0; i < 4; i++) step_b(-128);
    chk("t6_lock",   32'(locked_b), 32'd1);
    chk("t6_phase0", 32'(phase_b),  32'd0);
    @(negedge clk);
    bus_b.i_enable = 1'b0;

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
